melody_sequencer: RTL and testbench

Parametrised, loadable note-sequence player with a built-in square-wave tone generator. It supersedes the fixed auto-play / tone-out pair in the scale game.
- Game logic writes a phrase into an internal note RAM, then pulses `start`.
- The block steps through the first `length` notes, one per note slot, with optional looping and an inter-note silence.
- It presents each note index to the external tone table and drives `buzz` from the half-period divider the table returns.

---
 rtl/melody_pkg.sv | 13 +
 rtl/tone_pwm.sv | 36 +++
 rtl/melody_sequencer.sv | 153 +++++++++++++++
 tb/tb_melody_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: playback state encoding and the
// note index that means "silence".
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } mel_state_t;

    localparam int NOTE_REST = 0;

endpackage

// File: rtl/tone_pwm.sv
// Square-wave generator: buzz toggles every tone_div cycles while enabled and
// always restarts from counter 0 / buzz 0.
module tone_pwm #(
    parameter int DIV_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [DIV_W-1:0] tone_div,
    output logic             buzz
);

    logic [DIV_W-1:0] cnt_q;
    logic             buzz_q;

    // The >= compare lets a shortened half-period take effect at the very next
    // compare instead of waiting for the counter to wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else if (restart || !enable || (tone_div == '0)) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else if (cnt_q >= (tone_div - DIV_W'(1))) begin
            cnt_q  <= '0;
            buzz_q <= ~buzz_q;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    assign buzz = buzz_q;

endmodule

// File: rtl/melody_sequencer.sv
// Loadable note-phrase player: note RAM, slot timer and playback FSM driving an
// external tone table and the tone_pwm square-wave generator.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int NOTE_W   = 5,
    parameter int DIV_W    = 15,
    parameter int MAX_LEN  = 32,
    parameter int NOTE_CYC = 12_000_000,
    parameter int GAP_CYC  = 3_000_000,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int AW      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [LEN_W-1:0]  length,
    input  logic              loop_en,
    // start is taken only while busy=0 and stop=0; every accepted start ends in
    // exactly one done pulse (natural end, stop, or an empty phrase).
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  tone_div,
    output logic [NOTE_W-1:0] play_index,
    output logic              buzz,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int SLOT_MAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int CW       = $clog2(SLOT_MAX + 1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    mel_state_t        state_q;
    logic [AW-1:0]     idx_q;
    logic [LEN_W-1:0]  len_q;
    logic              loop_q;
    logic [CW-1:0]     slot_q;
    logic [NOTE_W-1:0] play_index_q;
    logic              busy_q;
    logic              done_q;
    logic [NOTE_W-1:0] ram_q [MAX_LEN];

    logic [LEN_W-1:0]  len_d;
    logic              tone_done;
    logic              note_end;
    logic              has_next;

    assign len_d     = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign tone_done = (state_q == TONE) && (slot_q == NOTE_LAST);
    assign note_end  = ((state_q == GAP) && (slot_q == GAP_LAST)) ||
                       ((GAP_CYC == 0) && tone_done);
    assign has_next  = (LEN_W'(idx_q) + LEN_W'(1)) < len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) ram_q[i] <= '0;
        end else if (wr_en) begin
            ram_q[wr_addr] <= wr_note;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            slot_q       <= '0;
            play_index_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        len_q  <= len_d;
                        loop_q <= loop_en;
                        idx_q  <= '0;
                        slot_q <= '0;
                        if (len_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= TONE;
                            busy_q       <= 1'b1;
                            play_index_q <= ram_q[0];
                        end
                    end
                end
                TONE, GAP: begin
                    if (stop) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        idx_q        <= '0;
                        slot_q       <= '0;
                        play_index_q <= '0;
                    end else if (note_end) begin
                        slot_q <= '0;
                        if (has_next) begin
                            state_q      <= TONE;
                            idx_q        <= idx_q + AW'(1);
                            play_index_q <= ram_q[idx_q + AW'(1)];
                        end else if (loop_q) begin
                            state_q      <= TONE;
                            idx_q        <= '0;
                            play_index_q <= ram_q[0];
                        end else begin
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            idx_q        <= '0;
                            play_index_q <= '0;
                        end
                    end else if (tone_done) begin
                        state_q      <= GAP;
                        slot_q       <= '0;
                        play_index_q <= '0;
                    end else begin
                        slot_q <= slot_q + CW'(1);
                        // Re-read every cycle so a RAM write to the playing note shows up mid-note.
                        if (state_q == TONE) play_index_q <= ram_q[idx_q];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Restart at every slot boundary so the next note begins from a fresh phase
    // and the gap/idle cycle after a note never sees a late toggle.
    tone_pwm #(
        .DIV_W (DIV_W)
    ) u_tone_pwm (
        .clk      (clk),
        .reset    (reset),
        .enable   ((state_q == TONE) && (play_index_q != NOTE_W'(NOTE_REST))),
        .restart  (tone_done || stop),
        .tone_div (tone_div),
        .buzz     (buzz)
    );

    assign play_index = play_index_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with NOTE_CYC=8, GAP_CYC=2, MAX_LEN=8 and an
// identity tone table (tone_div = play_index) unless the override is enabled.
module tb_melody_sequencer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_note;
    logic [3:0]  length;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic [14:0] tone_div;
    logic [4:0]  play_index;
    logic        buzz;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    logic        use_ovr;
    logic [14:0] div_ovr;

    int total;
    int bad;

    assign tone_div = use_ovr ? div_ovr : {10'd0, play_index};

    melody_sequencer #(
        .NOTE_W   (5),
        .DIV_W    (15),
        .MAX_LEN  (8),
        .NOTE_CYC (8),
        .GAP_CYC  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .length     (length),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .tone_div   (tone_div),
        .play_index (play_index),
        .buzz       (buzz),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_ram(input logic [2:0] a, input logic [4:0] n);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = n;
        tick();
        wr_en   = 1'b0;
    endtask

    // Returns just after the accepting edge E (offset k=0).
    task automatic do_start(input logic [3:0] l, input logic lp);
        length  = l;
        loop_en = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0][4:0] notes;   // listed from address 7 down to address 0
        logic [3:0]      len;
        int              done_at; // offset of the done pulse after the start edge
    } phrase_t;

    phrase_t    vec [5];
    logic [4:0] exp_q [$];

    int         pos;
    int         slot;
    int         dcnt;
    logic [4:0] e_idx;
    logic       e_buzz;
    logic       e_busy;
    logic       e_done;
    logic [7:0] bz_exp;

    initial begin
        vec[0] = '{notes: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd3}, len: 4'd3,  done_at: 30};
        vec[1] = '{notes: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd1}, len: 4'd1,  done_at: 10};
        vec[2] = '{notes: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5}, len: 4'd0,  done_at: 0};
        vec[3] = '{notes: {5'd7, 5'd6, 5'd5, 5'd4, 5'd0, 5'd1, 5'd3, 5'd2}, len: 4'd12, done_at: 80};
        vec[4] = '{notes: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd6}, len: 4'd2,  done_at: 20};

        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_note = '0;
        length  = '0;
        loop_en = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        use_ovr = 1'b0;
        div_ovr = '0;

        // ---- reset state ----
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset play_index", play_index, 0);
        check("reset buzz", buzz, 0);
        check("reset state", dbg_state, 0);
        reset = 1'b1;
        tick();

        // ---- table-driven one-shot phrases ----
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 8; a++) write_ram(3'(a), vec[r].notes[a]);
            do_start(vec[r].len, 1'b0);
            for (int k = 0; k <= vec[r].done_at + 1; k++) begin
                slot   = k / 10;
                pos    = k % 10;
                e_busy = (k < vec[r].done_at);
                e_done = (k == vec[r].done_at);
                e_idx  = '0;
                if (e_busy && pos < 8) e_idx = vec[r].notes[slot];
                e_buzz = (e_idx != 0) && (((pos / int'(e_idx)) % 2) == 1);
                check($sformatf("r%0d k%0d busy", r, k), busy, e_busy);
                check($sformatf("r%0d k%0d done", r, k), done, e_done);
                check($sformatf("r%0d k%0d play_index", r, k), play_index, e_idx);
                check($sformatf("r%0d k%0d buzz", r, k), buzz, e_buzz);
                tick();
            end
        end

        // ---- loop with stop ----
        write_ram(3'd0, 5'd1);
        write_ram(3'd1, 5'd2);
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd1);
        do_start(4'd2, 1'b1);
        for (int k = 0; k < 25; k++) begin
            if (k == 0 || k == 8 || k == 10 || k == 18 || k == 20 || k == 23)
                check($sformatf("loop k%0d play_index", k), play_index, exp_q.pop_front());
            if (k == 0) check("loop k0 state", dbg_state, 1);
            if (k == 8) check("loop k8 state", dbg_state, 2);
            if (k == 22) check("loop k22 busy", busy, 1);
            if (k == 24) stop = 1'b1;
            tick();
        end
        check("loop stop busy", busy, 0);
        check("loop stop done", done, 1);
        check("loop stop play_index", play_index, 0);
        check("loop stop buzz", buzz, 0);
        stop = 1'b0;
        tick();
        check("loop after stop done", done, 0);
        check("loop after stop state", dbg_state, 0);

        // ---- start together with stop in IDLE ----
        length = 4'd3;
        start  = 1'b1;
        stop   = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start+stop busy", busy, 0);
        check("start+stop done", done, 0);
        check("start+stop state", dbg_state, 0);
        tick();
        check("start+stop later done", done, 0);

        // ---- start pulsed while busy ----
        write_ram(3'd0, 5'd3);
        write_ram(3'd1, 5'd0);
        write_ram(3'd2, 5'd2);
        do_start(4'd3, 1'b0);
        for (int k = 0; k <= 31; k++) begin
            if (k == 20) check("rebusy k20 play_index", play_index, 2);
            if (k == 29) check("rebusy k29 busy", busy, 1);
            if (k == 29) check("rebusy k29 done", done, 0);
            if (k == 30) check("rebusy k30 busy", busy, 0);
            if (k == 30) check("rebusy k30 done", done, 1);
            if (k == 31) check("rebusy k31 done", done, 0);
            if (k == 31) check("rebusy k31 state", dbg_state, 0);
            if (k == 5) begin
                start   = 1'b1;
                length  = 4'd1;
                loop_en = 1'b1;
            end
            if (k == 6) begin
                start   = 1'b0;
                loop_en = 1'b0;
            end
            if (k < 31) tick();
        end
        tick();

        // ---- stop on the natural end cycle ----
        write_ram(3'd0, 5'd1);
        do_start(4'd1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 9) stop = 1'b1;
            tick();
        end
        check("stop_end busy", busy, 0);
        dcnt = 0;
        for (int k = 10; k < 14; k++) begin
            dcnt += int'(done);
            if (k == 10) stop = 1'b0;
            tick();
        end
        check("stop_end done pulses", dcnt, 1);

        // ---- asynchronous reset mid-note ----
        write_ram(3'd0, 5'd3);
        write_ram(3'd1, 5'd0);
        write_ram(3'd2, 5'd2);
        do_start(4'd3, 1'b0);
        repeat (4) tick();
        check("rst pre buzz", buzz, 1);
        check("rst pre play_index", play_index, 3);
        #2 reset = 1'b0;
        #1;
        check("rst async buzz", buzz, 0);
        check("rst async play_index", play_index, 0);
        check("rst async busy", busy, 0);
        check("rst async done", done, 0);
        #2 reset = 1'b1;
        tick();
        do_start(4'd3, 1'b0);
        for (int k = 0; k <= 30; k++) begin
            if (k == 0 || k == 10 || k == 20)
                check($sformatf("rst k%0d play_index", k), play_index, 0);
            if (k == 3 || k == 4) check($sformatf("rst k%0d buzz", k), buzz, 0);
            if (k == 30) check("rst k30 done", done, 1);
            if (k < 30) tick();
        end
        tick();

        // ---- live tone_div change and write to the playing address ----
        write_ram(3'd0, 5'd4);
        use_ovr = 1'b1;
        div_ovr = 15'd4;
        bz_exp  = 8'b1001_1000;
        do_start(4'd1, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) check($sformatf("live k%0d buzz", k), buzz, bz_exp[k]);
            if (k == 4) check("live k4 play_index", play_index, 4);
            if (k == 5) check("live k5 play_index", play_index, 9);
            if (k == 10) check("live k10 done", done, 1);
            if (k == 2) div_ovr = 15'd2;
            if (k == 3) begin
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_note = 5'd9;
            end
            if (k == 4) wr_en = 1'b0;
            if (k < 10) tick();
        end
        use_ovr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
